instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Producer side of the decode interface: fetches instruction words from instruction memory and presents them, one per handshake, to the decoder.
- Owns the PC. Keeps at most one memory request in flight and holds returned words in a 2-entry buffer.
- Stops prefetching once it buffers a HALT opcode. Redirect (branch/jump) flushes the buffer and restarts fetch at a new PC.

Parameters:
- INSTR_W, `InstrWidth (16): instruction word width.
- OP_W, `OpWidth (4): opcode field width; the opcode is instr[INSTR_W-1 -: OP_W].
- PC_W, 16: PC/address width; word addressed.
- RESET_PC, 0: first fetch address after reset.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_req  out  1  fetch request valid
- mem_addr  out  PC_W  fetch word address
- mem_gnt  in  1  request accepted this cycle (sampled only while mem_req=1)
- mem_rvalid  in  1  read data returned, ≥1 cycle after gnt
- mem_rdata  in  INSTR_W  returned word
- instr  out  INSTR_W  buffer head word, to decoder
- instr_pc  out  PC_W  address of instr
- instr_valid  out  1  buffer non-empty
- instr_ready  in  1  decoder consumes head when valid&ready
- redirect_en  in  1  flush and restart fetch
- redirect_pc  in  PC_W  new fetch address
- fetch_stopped  out  1  HALT buffered; no further requests

Behaviour:
- Reset (async assert): state=S_REQ, pc=RESET_PC, buffer empty.
  - All outputs 0 while rst_n=0: mem_req, mem_addr, instr, instr_pc, instr_valid, fetch_stopped.
  - First request appears in the first cycle after deassertion.
- States:
  - S_REQ: mem_req=1, mem_addr=pc. On gnt: pc<=pc+1 (wraps mod 2^PC_W), capture req_pc, go to S_WAIT.
  - S_WAIT: mem_req=0. On rvalid: push {mem_rdata, req_pc}.
    - If the pushed opcode == `OP_HALT, go to S_HALT.
    - Else go to S_REQ if a buffer slot is free after this cycle's push/pop, otherwise S_FULL.
  - S_FULL: mem_req=0. Go to S_REQ the cycle after a pop.
  - S_HALT: mem_req=0, fetch_stopped=1. Buffered words still drain normally. Exit only via redirect or reset.
  - S_DRAIN: mem_req=0. Wait for the in-flight rvalid, discard the data, then go to S_REQ.
- Request rule:
  - mem_req is asserted only if count + outstanding < 2, so a response never finds the buffer full.
  - mem_addr must stay stable while mem_req=1 and gnt=0, except on redirect.
  - Memory only acts on a request in its gnt cycle, so withdrawing an ungranted request is legal.
- Buffer: 2-entry FIFO. Push and pop in the same cycle is allowed with count unchanged. Pop when empty is a no-op.
- Latency: with gnt in the same cycle as req and rvalid on the next cycle, instr_valid rises 2 cycles after mem_req rises. Zero-latency bypass is not required.
- Redirect (highest priority, takes effect at the clock edge):
  - Buffer cleared, so instr_valid=0 next cycle; a pop in the same cycle is ignored.
  - pc <= redirect_pc; fetch_stopped <= 0.
  - If a request is outstanding (S_WAIT, or gnt in this cycle), go to S_DRAIN; otherwise go to S_REQ.
  - rvalid in the redirect cycle is discarded (counts as the drain completing, so go to S_REQ).
- A second redirect while in S_DRAIN updates pc and stays in S_DRAIN.
- Reset mid-transaction: any in-flight response arriving after reset is ignored, because state is S_REQ with outstanding=0 and rvalid is masked outside S_WAIT/S_DRAIN.
- instr/instr_pc hold their value while valid&!ready.

Decomposition:
- defs.svh: `InstrWidth, `OpWidth, `OP_HALT (shared with the decoder) plus new fetch state encodings (`FS_REQ, `FS_WAIT, `FS_FULL, `FS_HALT, `FS_DRAIN, 3 bits).
- Sub-module fetch_buf: 2-entry FIFO of {instr, pc} with push/pop/flush and count output.
- instr_fetch holds the FSM, PC and request logic.

Test Plan:
- Reset then a memory with 1-cycle latency returning 0x1000+addr, ready=1 → instr 0x1000,0x1001,0x1002 at instr_pc 0,1,2. Steady rate is one word per 2 cycles.
- ready=0 for 10 cycles → exactly 2 words buffered, mem_req=0 throughout. On ready=1, 0x1000 pops first, the next request is issued the cycle after the pop, and no word is lost or duplicated.
- Word at addr 3 has opcode `OP_HALT → fetch_stopped=1, no request to addr 4, words 0–3 delivered, then instr_valid=0.
- redirect_pc=0x40 while in S_WAIT for addr 2 → the addr-2 response is discarded, the next mem_addr is 0x40, and the first instr after the redirect has instr_pc 0x40.
- Redirect and rvalid in the same cycle, with a pop also in that cycle → the data is dropped, the buffer is empty next cycle, and fetch resumes at redirect_pc with no S_DRAIN.
- rst_n pulsed low asynchronously mid-S_WAIT → outputs 0 immediately. A stale rvalid one cycle after release is ignored, and fetch restarts at RESET_PC.
- PC wrap: redirect to 0xFFFF → fetches 0xFFFF then 0x0000.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared fetch definitions: word/opcode widths, the HALT opcode and fetch FSM states.
package instr_fetch_pkg;

  localparam int unsigned InstrWidth = 16;
  localparam int unsigned OpWidth    = 4;

  localparam logic [OpWidth-1:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_FULL  = 3'd2,
    S_HALT  = 3'd3,
    S_DRAIN = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Memory request/response and decoder handshake signals of the fetch unit.
interface instr_fetch_if #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned PC_W    = 16
);
  logic               mem_req;
  logic [PC_W-1:0]    mem_addr;
  logic               mem_gnt;
  logic               mem_rvalid;
  logic [INSTR_W-1:0] mem_rdata;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic               redirect_en;
  logic [PC_W-1:0]    redirect_pc;
  logic               fetch_stopped;

  modport master (
    output mem_req, mem_addr, instr, instr_pc, instr_valid, fetch_stopped,
    input  mem_gnt, mem_rvalid, mem_rdata, instr_ready, redirect_en, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, instr, instr_pc, instr_valid, fetch_stopped,
    output mem_gnt, mem_rvalid, mem_rdata, instr_ready, redirect_en, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_buf.sv
// Two-entry FIFO of {instr, pc}; flush wins over push/pop, pop on empty is ignored.
module fetch_buf #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         pop_ok;
  logic         push_ok;

  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'd2) || pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push_ok) - 2'(pop_ok);
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues one memory request at a time and
// feeds returned words to the decoder through a 2-entry buffer.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned     INSTR_W  = InstrWidth,
  parameter int unsigned     OP_W     = OpWidth,
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);
  localparam int unsigned EW = INSTR_W + PC_W;

  fetch_state_e    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] req_pc;
  logic            started;
  logic            req_fire;
  logic            pop;
  logic            push;
  logic            slot_free;
  logic            is_halt;
  logic [1:0]      count;
  logic [EW-1:0]   head;

  // started keeps mem_req/mem_addr low until the first edge after reset release.
  assign bus.mem_req       = started && (state == S_REQ);
  assign bus.mem_addr      = started ? pc : '0;
  assign bus.fetch_stopped = (state == S_HALT);
  assign bus.instr_valid   = (count != 2'd0);
  assign bus.instr         = head[EW-1 -: INSTR_W];
  assign bus.instr_pc      = head[PC_W-1:0];

  assign req_fire  = bus.mem_req && bus.mem_gnt;
  assign pop       = bus.instr_valid && bus.instr_ready;
  assign push      = (state == S_WAIT) && bus.mem_rvalid && !bus.redirect_en;
  assign is_halt   = (bus.mem_rdata[INSTR_W-1 -: OP_W] == OP_W'(OP_HALT));
  // A push only happens from S_WAIT, where count is at most 1.
  assign slot_free = (count == 2'd0) || pop;

  fetch_buf #(.W(EW)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_en),
    .wdata ({bus.mem_rdata, req_pc}),
    .rdata (head),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      req_pc  <= '0;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      if (bus.redirect_en) begin
        pc <= bus.redirect_pc;
        // An rvalid in the redirect cycle retires the outstanding request.
        if (req_fire || (((state == S_WAIT) || (state == S_DRAIN)) && !bus.mem_rvalid)) begin
          state <= S_DRAIN;
        end else begin
          state <= S_REQ;
        end
      end else begin
        case (state)
          S_REQ: begin
            if (req_fire) begin
              pc     <= pc + PC_W'(1);
              req_pc <= pc;
              state  <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (bus.mem_rvalid) begin
              if (is_halt)        state <= S_HALT;
              else if (slot_free) state <= S_REQ;
              else                state <= S_FULL;
            end
          end
          S_FULL:  if (pop) state <= S_REQ;
          S_HALT:  state <= S_HALT;
          S_DRAIN: if (bus.mem_rvalid) state <= S_REQ;
          default: state <= S_REQ;
        endcase
      end
    end
  end
endmodule
